// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready handshake.
// Fixed mode: the highest set index wins. Round-robin mode: a rotating start pointer searches downward.
module prio_encoder_rr #(
    parameter int WIDTH   = 8,
    parameter int IDX_W   = $clog2(WIDTH),
    parameter int RR_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [WIDTH-1:0] grant_o,
    output logic             none_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);

    // Walk downward from start, wrapping modulo WIDTH, and take the first set bit.
    // The result is {hit, index}. A start of TOP_IDX reproduces fixed priority.
    function automatic logic [IDX_W:0] search_down(input logic [WIDTH-1:0] req,
                                                   input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] pos;
        logic [IDX_W-1:0] win;
        logic             hit;
        win = '0;
        hit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            pos = start - IDX_W'(i);
            if (!hit && req[pos]) begin
                win = pos;
                hit = 1'b1;
            end
        end
        return {hit, win};
    endfunction

    function automatic logic [WIDTH-1:0] onehot(input logic [IDX_W-1:0] idx, input logic hit);
        return hit ? (WIDTH'(1) << idx) : '0;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] win);
        return (win == '0) ? TOP_IDX : win - IDX_W'(1);
    endfunction

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] start_p0;
    logic [IDX_W:0]   found_p0;
    logic [IDX_W-1:0] win_p0;
    logic             hit_p0;
    logic             cap_p0;

    logic [IDX_W-1:0] idx_p1;
    logic [WIDTH-1:0] grant_p1;
    logic             none_p1;
    logic             vld_p1;

    // Stage 0: combinational search on the incoming vector
    assign start_p0    = (RR_MODE != 0) ? ptr : TOP_IDX;
    assign found_p0    = search_down(req_i, start_p0);
    assign win_p0      = found_p0[IDX_W-1:0];
    assign hit_p0      = found_p0[IDX_W];
    assign req_ready_o = !vld_p1 || out_ready_i;
    assign cap_p0      = req_valid_i && req_ready_o;

    // Stage 1: one-entry output register; capture may coincide with drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            idx_p1   <= '0;
            grant_p1 <= '0;
            none_p1  <= 1'b0;
            ptr      <= TOP_IDX;
        end else begin
            if (cap_p0) begin
                vld_p1   <= 1'b1;
                idx_p1   <= win_p0;
                grant_p1 <= onehot(win_p0, hit_p0);
                none_p1  <= !hit_p0;
                if (hit_p0) begin
                    ptr <= next_ptr(win_p0);
                end
            end else if (out_ready_i) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign idx_o       = idx_p1;
    assign grant_o     = grant_p1;
    assign none_o      = none_p1;
    assign out_valid_o = vld_p1;

endmodule
